// File: rtl/ds_echo_pkg.sv
// Shared types and constants for the data-stream echo responder.
package ds_echo_pkg;

  localparam int unsigned CNT_W     = 32;
  // Payload container is sized to the widest supported stream.
  localparam int unsigned DS_DATA_W = 293;
  localparam int unsigned DS_ADDR_W = 4;

  typedef logic [0:0] rx_state_t;
  localparam rx_state_t RX_IDLE = 1'b0;
  localparam rx_state_t RX_PKT  = 1'b1;

  typedef logic [0:0] tx_state_t;
  localparam tx_state_t TX_IDLE = 1'b0;
  localparam tx_state_t TX_SEND = 1'b1;

  typedef struct packed {
    logic                 eop;
    logic [DS_DATA_W-1:0] data;
  } beat_t;

  localparam int unsigned BEAT_W = $bits(beat_t);

  // Wrapping increment for the statistics counters.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ds_echo_responder_fifo.sv
// Synchronous FIFO: registered write, show-ahead read, full/empty flags.
module ds_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_go, rd_go;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_comb begin
    o_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    o_empty  = (wr_ptr_q == rd_ptr_q);
    wr_go    = i_wr_en && !o_full;
    rd_go    = i_rd_en && !o_empty;
    wr_ptr_d = wr_go ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = rd_go ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    o_rd_data = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers; reset flushes the contents.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, written at the tail.
  always_ff @(posedge i_clk) begin
    if (wr_go) mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/ds_echo_responder.sv
// Loopback responder: buffers NAP rx packets and echoes them to their source.
module ds_echo_responder
  import ds_echo_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = DS_DATA_W,
  parameter int unsigned           ADDR_WIDTH = DS_ADDR_W,
  parameter int unsigned           DATA_DEPTH = 64,
  parameter int unsigned           HDR_DEPTH  = 8,
  parameter logic [DATA_WIDTH-1:0] XOR_MASK   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rx_valid,
  input  logic                  i_rx_sop,
  input  logic                  i_rx_eop,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [ADDR_WIDTH-1:0] i_rx_src,
  output logic                  o_rx_ready,
  output logic                  o_tx_valid,
  output logic                  o_tx_sop,
  output logic                  o_tx_eop,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [ADDR_WIDTH-1:0] o_tx_dest,
  input  logic                  i_tx_ready,
  output logic [CNT_W-1:0]      o_rx_pkt_cnt,
  output logic [CNT_W-1:0]      o_tx_pkt_cnt,
  output logic                  o_framing_err
);

  // Enough range for one complete packet per beat slot.
  localparam int unsigned CPKT_W = $clog2(DATA_DEPTH) + 1;

  rx_state_t             rx_state_q, rx_state_d;
  tx_state_t             tx_state_q, tx_state_d;
  logic                  first_q, first_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;
  logic [CPKT_W-1:0]     cpkt_q, cpkt_d;
  logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic                  err_q, err_d;

  beat_t                 wr_beat, rd_beat;
  logic                  d_wr_en, d_rd_en, d_full, d_empty;
  logic                  h_wr_en, h_rd_en, h_full, h_empty;
  logic [ADDR_WIDTH-1:0] h_rd_data;

  logic                  rx_acc, tx_acc, tx_send;
  logic                  rx_eop_done, tx_eop_done, cpkt_dec;

  // Beat buffer: {eop, masked data}.
  ds_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (DATA_DEPTH)
  ) u_beat_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (d_wr_en),
    .i_wr_data (wr_beat),
    .i_rd_en   (d_rd_en),
    .o_rd_data (rd_beat),
    .o_full    (d_full),
    .o_empty   (d_empty)
  );

  // Header buffer: one source address per packet.
  ds_sync_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (HDR_DEPTH)
  ) u_hdr_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (h_wr_en),
    .i_wr_data (i_rx_src),
    .i_rd_en   (h_rd_en),
    .o_rd_data (h_rd_data),
    .o_full    (h_full),
    .o_empty   (h_empty)
  );

  // Handshakes; nothing transfers in either direction during reset.
  always_comb begin
    o_rx_ready = !i_reset && !d_full && !(h_full && (rx_state_q == RX_IDLE));
    rx_acc     = i_rx_valid && o_rx_ready;
    tx_send    = (tx_state_q == TX_SEND);
    o_tx_valid = !i_reset && tx_send && !d_empty;
    tx_acc     = o_tx_valid && i_tx_ready;
    o_tx_sop   = tx_send && first_q;
    o_tx_eop   = tx_send && !d_empty && rd_beat.eop;
    o_tx_data  = tx_send ? DATA_WIDTH'(rd_beat.data) : '0;
    o_tx_dest  = dest_q;
  end

  // RX FSM: frame checking and buffer writes.
  always_comb begin
    rx_state_d   = rx_state_q;
    d_wr_en      = 1'b0;
    h_wr_en      = 1'b0;
    err_d        = err_q;
    rx_eop_done  = 1'b0;
    wr_beat.eop  = i_rx_eop;
    wr_beat.data = DS_DATA_W'(i_rx_data ^ XOR_MASK);
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_acc) begin
          if (i_rx_sop) begin
            h_wr_en = 1'b1;
            d_wr_en = 1'b1;
            if (i_rx_eop) rx_eop_done = 1'b1;
            else          rx_state_d  = RX_PKT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        if (rx_acc) begin
          d_wr_en = 1'b1;
          if (i_rx_sop) err_d = 1'b1;
          if (i_rx_eop) begin
            rx_eop_done = 1'b1;
            rx_state_d  = RX_IDLE;
          end
        end
      end
    endcase
  end

  // TX FSM: starts on a complete packet, or on a full buffer to avoid deadlock.
  always_comb begin
    tx_state_d  = tx_state_q;
    first_d     = first_q;
    dest_d      = dest_q;
    h_rd_en     = 1'b0;
    d_rd_en     = 1'b0;
    tx_eop_done = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!h_empty && ((cpkt_q != '0) || d_full)) begin
          tx_state_d = TX_SEND;
          h_rd_en    = 1'b1;
          dest_d     = h_rd_data;
          first_d    = 1'b1;
        end
      end
      default: begin
        if (tx_acc) begin
          d_rd_en = 1'b1;
          first_d = 1'b0;
          if (rd_beat.eop) begin
            tx_eop_done = 1'b1;
            tx_state_d  = TX_IDLE;
          end
        end
      end
    endcase
  end

  // Complete-packet and statistics counters.
  always_comb begin
    cpkt_dec = tx_eop_done && ((cpkt_q != '0) || rx_eop_done);
    cpkt_d   = cpkt_q;
    if (rx_eop_done && !cpkt_dec)      cpkt_d = cpkt_q + CPKT_W'(1);
    else if (!rx_eop_done && cpkt_dec) cpkt_d = cpkt_q - CPKT_W'(1);
    rx_cnt_d = rx_eop_done ? cnt_inc(rx_cnt_q) : rx_cnt_q;
    tx_cnt_d = tx_eop_done ? cnt_inc(tx_cnt_q) : tx_cnt_q;
    o_rx_pkt_cnt  = rx_cnt_q;
    o_tx_pkt_cnt  = tx_cnt_q;
    o_framing_err = err_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_state_q <= RX_IDLE;
      tx_state_q <= TX_IDLE;
      first_q    <= 1'b0;
      dest_q     <= '0;
      cpkt_q     <= '0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      first_q    <= first_d;
      dest_q     <= dest_d;
      cpkt_q     <= cpkt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ds_echo_responder.sv
// Self-checking bench for ds_echo_responder.
module tb_ds_echo_responder;
  import ds_echo_pkg::*;

  localparam int unsigned DW = 293;
  localparam int unsigned AW = 4;
  localparam int unsigned DD = 16;
  localparam int unsigned HD = 8;
  localparam logic [DW-1:0] MASK = {5'h15, {9{32'hA5C3_0F69}}};

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_rx_valid, i_rx_sop, i_rx_eop;
  logic [DW-1:0] i_rx_data;
  logic [AW-1:0] i_rx_src;
  logic          o_rx_ready;
  logic          o_tx_valid, o_tx_sop, o_tx_eop;
  logic [DW-1:0] o_tx_data;
  logic [AW-1:0] o_tx_dest;
  logic          i_tx_ready = 1'b0;
  logic [31:0]   o_rx_pkt_cnt, o_tx_pkt_cnt;
  logic          o_framing_err;

  ds_echo_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DATA_DEPTH (DD),
    .HDR_DEPTH  (HD),
    .XOR_MASK   (MASK)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_rx_valid    (i_rx_valid),
    .i_rx_sop      (i_rx_sop),
    .i_rx_eop      (i_rx_eop),
    .i_rx_data     (i_rx_data),
    .i_rx_src      (i_rx_src),
    .o_rx_ready    (o_rx_ready),
    .o_tx_valid    (o_tx_valid),
    .o_tx_sop      (o_tx_sop),
    .o_tx_eop      (o_tx_eop),
    .o_tx_data     (o_tx_data),
    .o_tx_dest     (o_tx_dest),
    .i_tx_ready    (i_tx_ready),
    .o_rx_pkt_cnt  (o_rx_pkt_cnt),
    .o_tx_pkt_cnt  (o_tx_pkt_cnt),
    .o_framing_err (o_framing_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    int n_pkts;
    int len;
    int src0;
    int mode;
    bit want_stall;
    bit want_cut;
  } vec_t;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            txr_mode = 0;
  int            push_cnt = 0;
  int            pop_cnt  = 0;
  int            m_cur_start = 0;
  int            m_rx_pkts = 0;
  bit            m_in_pkt = 1'b0;
  logic [AW-1:0] m_dest = '0;
  bit            saw_stall = 1'b0;
  bit            cut_seen = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < 10; i++) r = {r[DW-33:0], 32'($urandom)};
    return r;
  endfunction

  // Reference model of the rx framing rules; queues the expected echo.
  task automatic model_accept(input logic sop, input logic eop, input logic [AW-1:0] src,
                              input logic [DW-1:0] d);
    if (!m_in_pkt) begin
      if (sop) begin
        m_cur_start = push_cnt;
        m_dest = src;
        sb_q.push_back('{sop: 1'b1, eop: eop, dest: src, data: d ^ MASK});
        push_cnt++;
        if (eop) m_rx_pkts++;
        else     m_in_pkt = 1'b1;
      end
    end else begin
      sb_q.push_back('{sop: 1'b0, eop: eop, dest: m_dest, data: d ^ MASK});
      push_cnt++;
      if (eop) begin
        m_in_pkt = 1'b0;
        m_rx_pkts++;
      end
    end
  endtask

  // Offer one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic sop, input logic eop, input logic [AW-1:0] src,
                           input logic [DW-1:0] d);
    int  waits = 0;
    bit  done = 1'b0;
    i_rx_valid = 1'b1;
    i_rx_sop   = sop;
    i_rx_eop   = eop;
    i_rx_src   = src;
    i_rx_data  = d;
    while (!done) begin
      @(negedge i_clk);
      if (o_rx_ready) begin
        model_accept(sop, eop, src, d);
        step();
        done = 1'b1;
      end else begin
        step();
        waits++;
        if (waits > 2000) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_ready_timeout: got ready=0 for %0d cycles expected ready", waits);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle_rx();
    i_rx_valid = 1'b0;
    i_rx_sop   = 1'b0;
    i_rx_eop   = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [AW-1:0] src);
    for (int b = 0; b < len; b++) send_beat(b == 0, b == len - 1, src, rnd_data());
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats outstanding expected 0", sb_q.size());
    end
    repeat (3) step();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_tx_valid"}, DW'(o_tx_valid), '0);
    chk({tag, "_tx_sop"},   DW'(o_tx_sop), '0);
    chk({tag, "_tx_eop"},   DW'(o_tx_eop), '0);
    chk({tag, "_tx_data"},  o_tx_data, '0);
    chk({tag, "_tx_dest"},  DW'(o_tx_dest), '0);
    chk({tag, "_rx_cnt"},   DW'(o_rx_pkt_cnt), '0);
    chk({tag, "_tx_cnt"},   DW'(o_tx_pkt_cnt), '0);
    chk({tag, "_err"},      DW'(o_framing_err), '0);
    chk({tag, "_rx_ready"}, DW'(o_rx_ready), DW'(1'b1));
  endtask

  // tx_ready pattern: 0 = always, 1 = random 50%, 2 = held low.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      case (txr_mode)
        0:       i_tx_ready = 1'b1;
        1:       i_tx_ready = 1'($urandom_range(0, 1));
        default: i_tx_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard: compare every accepted tx beat against the queued expectation.
  always @(negedge i_clk) begin : mon
    exp_t e;
    if (i_rx_valid && !o_rx_ready && !i_reset) saw_stall = 1'b1;
    if (o_tx_valid && i_tx_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tx: got beat dest=%0h data=%0h expected none", o_tx_dest, o_tx_data);
      end else begin
        if (m_in_pkt && pop_cnt >= m_cur_start) cut_seen = 1'b1;
        e = sb_q.pop_front();
        pop_cnt++;
        chk("tx_sop",  DW'(o_tx_sop),  DW'(e.sop));
        chk("tx_eop",  DW'(o_tx_eop),  DW'(e.eop));
        chk("tx_dest", DW'(o_tx_dest), DW'(e.dest));
        chk("tx_data", o_tx_data, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t          vecs[4];
    logic [DW-1:0] d0;
    logic [DW-1:0] dq[4];
    int            pop0;

    vecs[0] = '{3, 20, 7, 1, 1'b1, 1'b1};
    vecs[1] = '{1, 40, 2, 0, 1'b1, 1'b1};
    vecs[2] = '{5, 1, 9, 1, 1'b0, 1'b0};
    vecs[3] = '{2, 3, 12, 0, 1'b0, 1'b0};

    i_reset = 1'b1;
    idle_rx();
    i_rx_data = '0;
    i_rx_src  = '0;
    repeat (3) step();
    i_reset = 1'b0;
    @(negedge i_clk);
    chk_idle_outputs("reset");

    // Single-beat packet: valid with sop/eop two edges after acceptance.
    step();
    send_beat(1'b1, 1'b1, 4'h3, DW'(8'hA5));
    idle_rx();
    @(negedge i_clk);
    chk("lat_t1_valid", DW'(o_tx_valid), '0);
    step();
    @(negedge i_clk);
    chk("lat_t2_valid", DW'(o_tx_valid), DW'(1'b1));
    chk("lat_t2_sop",   DW'(o_tx_sop),   DW'(1'b1));
    chk("lat_t2_eop",   DW'(o_tx_eop),   DW'(1'b1));
    chk("lat_t2_dest",  DW'(o_tx_dest),  DW'(4'h3));
    chk("lat_t2_data",  o_tx_data, DW'(8'hA5) ^ MASK);
    step();
    wait_drain();
    chk("single_rx_cnt", DW'(o_rx_pkt_cnt), DW'(1));
    chk("single_tx_cnt", DW'(o_tx_pkt_cnt), DW'(1));

    // 4-beat packet held by tx backpressure: head beat must not change.
    txr_mode = 2;
    step();
    for (int b = 0; b < 4; b++) begin
      dq[b] = rnd_data();
      send_beat(b == 0, b == 3, 4'h5, dq[b]);
    end
    idle_rx();
    d0 = dq[0] ^ MASK;
    step();
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      chk("hold_valid", DW'(o_tx_valid), DW'(1'b1));
      chk("hold_sop",   DW'(o_tx_sop),   DW'(1'b1));
      chk("hold_data",  o_tx_data, d0);
      step();
    end
    txr_mode = 0;
    wait_drain();
    chk("hold_rx_cnt", DW'(o_rx_pkt_cnt), DW'(m_rx_pkts));
    chk("hold_tx_cnt", DW'(o_tx_pkt_cnt), DW'(m_rx_pkts));

    // Table of streaming scenarios: backpressure, oversize cut-through, short packets.
    for (int v = 0; v < 4; v++) begin
      txr_mode  = vecs[v].mode;
      step();
      saw_stall = 1'b0;
      cut_seen  = 1'b0;
      pop0      = pop_cnt;
      for (int p = 0; p < vecs[v].n_pkts; p++) send_pkt(vecs[v].len, AW'(vecs[v].src0 + p));
      idle_rx();
      wait_drain();
      chk($sformatf("vec%0d_beats", v), DW'(pop_cnt - pop0), DW'(vecs[v].n_pkts * vecs[v].len));
      chk($sformatf("vec%0d_stall", v), DW'(saw_stall), DW'(vecs[v].want_stall));
      chk($sformatf("vec%0d_cut", v),   DW'(cut_seen),  DW'(vecs[v].want_cut));
      chk($sformatf("vec%0d_rx_cnt", v), DW'(o_rx_pkt_cnt), DW'(m_rx_pkts));
      chk($sformatf("vec%0d_tx_cnt", v), DW'(o_tx_pkt_cnt), DW'(m_rx_pkts));
    end
    txr_mode = 0;

    // Framing: stray beat dropped, then sop inside a packet is a continuation.
    chk("frame_err_before", DW'(o_framing_err), '0);
    send_beat(1'b0, 1'b1, 4'h4, rnd_data());
    idle_rx();
    repeat (4) step();
    @(negedge i_clk);
    chk("frame_err_set",  DW'(o_framing_err), DW'(1'b1));
    chk("frame_rx_cnt",   DW'(o_rx_pkt_cnt), DW'(m_rx_pkts));
    step();
    send_beat(1'b1, 1'b0, 4'h6, rnd_data());
    send_beat(1'b0, 1'b0, 4'h6, rnd_data());
    send_beat(1'b1, 1'b0, 4'h6, rnd_data());
    send_beat(1'b0, 1'b0, 4'h6, rnd_data());
    send_beat(1'b0, 1'b1, 4'h6, rnd_data());
    idle_rx();
    wait_drain();
    chk("frame_err_sticky", DW'(o_framing_err), DW'(1'b1));
    chk("frame_tx_cnt",     DW'(o_tx_pkt_cnt), DW'(m_rx_pkts));

    // Reset with one packet queued for tx and a partial packet arriving.
    txr_mode = 2;
    step();
    send_pkt(3, 4'h1);
    send_beat(1'b1, 1'b0, 4'h2, rnd_data());
    send_beat(1'b0, 1'b0, 4'h2, rnd_data());
    idle_rx();
    step();
    @(negedge i_clk);
    chk("pre_reset_valid", DW'(o_tx_valid), DW'(1'b1));
    step();
    txr_mode = 0;
    step();
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("reset_cycle_valid", DW'(o_tx_valid), '0);
    step();
    i_reset = 1'b0;
    sb_q.delete();
    push_cnt    = 0;
    pop_cnt     = 0;
    m_cur_start = 0;
    m_rx_pkts   = 0;
    m_in_pkt    = 1'b0;
    @(negedge i_clk);
    chk_idle_outputs("mid_reset");
    repeat (3) step();
    @(negedge i_clk);
    chk("post_reset_quiet", DW'(o_tx_valid), '0);
    step();
    send_pkt(2, 4'hA);
    idle_rx();
    wait_drain();
    chk("post_reset_rx_cnt", DW'(o_rx_pkt_cnt), DW'(1));
    chk("post_reset_tx_cnt", DW'(o_tx_pkt_cnt), DW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
